nor_vector_gen: RTL and testbench
=================================

// Module: nor_vector_gen
// PURPOSE
//   Clocked stimulus/response stage that sits directly upstream of the 4-input NOR block.
//   Drives its inputs a,b,c,d through all 16 combinations, in binary order with a as the MSB.
//   Captures the 3-bit response {e,f,g} for each combination into a 16-entry result bank.
//   Folds every response into an 8-bit MISR signature for go/no-go checking on the board.
// PARAMETERS
//   DWELL   4  clock cycles each vector is held on a,b,c,d; legal range 2..255
//   SETTLE  2  cycle index within the dwell at which {e,f,g} is sampled; legal range 1..DWELL-1
// PORTS
//   clk      in   1  single clock; every flop is rising-edge
//   rst      in   1  asynchronous, active-high reset
//   start    in   1  level-sampled request to begin one 16-vector sweep
//   a        out  1  vector bit 3 (MSB)
//   b        out  1  vector bit 2
//   c        out  1  vector bit 1
//   d        out  1  vector bit 0 (LSB)
//   e        in   1  DUT response bit 2
//   f        in   1  DUT response bit 1
//   g        in   1  DUT response bit 0
//   busy     out  1  high while a sweep is in progress
//   done     out  1  one-cycle pulse when a sweep completes
//   rd_addr  in   4  result-bank read address
//   rd_data  out  3  result bank[rd_addr] = {e,f,g}; combinational read
//   sig      out  8  MISR signature of the current or last sweep
// BEHAVIOUR
//   Reset values (rst=1): a=b=c=d=0, busy=0, done=0, sig=8'h00, all 16 bank entries=3'b000,
//     FSM=IDLE, idx=0, dwell counter=0.
//   FSM states and transitions:
//     IDLE  -> APPLY on start=1. On that edge: idx=0, dwell counter=0, sig cleared to 8'h00.
//     APPLY -> DONE after the last dwell cycle of idx=15.
//     DONE  -> IDLE unconditionally after one cycle.
//   Vector outputs: {a,b,c,d} are registered.
//     In APPLY they equal idx; in IDLE and DONE they are 4'b0000.
//   Dwell counter: counts 0..DWELL-1 within each vector.
//     At DWELL-1, idx increments (4-bit) and the counter returns to 0.
//     idx never wraps inside a sweep: 15 exits to DONE.
//   Sampling: on the edge where the dwell counter = SETTLE:
//     bank[idx] <= {e,f,g};
//     sig <= {sig[6:0],1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {5'b0,e,f,g}.
//     This gives exactly one sample per vector, 16 per sweep.
//   busy = 1 exactly in APPLY: 16*DWELL cycles, with the first at the cycle after start is sampled.
//   done = 1 exactly in DONE; busy=0 in that cycle.
//   sig and the bank hold their values in IDLE until the next start or reset.
//   start while busy=1 or done=1 is ignored (no restart, no queuing).
//   start held high continuously gives back-to-back sweeps separated by one DONE cycle
//     and one IDLE cycle.
//   Reset asserted mid-sweep: all state returns to reset values immediately (async).
//     The bank is also cleared. No done pulse is produced for the aborted sweep.
//   rd_addr may change at any time; rd_data follows combinationally.
//     A read of the entry being written returns the old value until the write edge.
// TESTING
//   Bench models the DUT as e=~(a|b), f=~(c|d), g=~(a|b|c|d). DWELL=4, SETTLE=2 unless stated.
//   1) Reset, then 1-cycle start -> busy high for 64 cycles; done high in cycle 65 only;
//      a,b,c,d follow 0000..1111, each held 4 cycles, then return to 0000.
//   2) After sweep 1 -> rd_addr=0 gives 3'b111; rd_addr=5 gives 3'b000;
//      rd_addr=12 gives 3'b010; rd_addr=3 gives 3'b100.
//      sig equals the bench's MISR model of all 16 samples.
//   3) Pulse start again at busy cycle 20 -> no effect: single done at cycle 65, bank unchanged.
//   4) Assert rst while idx=7 -> same cycle: a..d=0000, busy=0, sig=00, all rd_data=000;
//      no done. Then start -> a full clean 64-cycle sweep.
//   5) start held high for 200 cycles -> back-to-back sweeps; done pulses 66 cycles apart;
//      sig is identical after each sweep.
//   6) DWELL=2, SETTLE=1, and a DUT forcing g stuck at 1 -> busy lasts 32 cycles;
//      bank LSB=1 at all 16 addresses; sig differs from the golden value.

Source files
------------

// File: rtl/nor_vector_gen_if.sv
// nor_vector_gen_if: vector, response, control and result-bank signals of the NOR stimulus stage
interface nor_vector_gen_if;
  logic       start;
  logic       a, b, c, d;
  logic       e, f, g;
  logic       busy, done;
  logic [3:0] rd_addr;
  logic [2:0] rd_data;
  logic [7:0] sig;
  modport master (input start, e, f, g, rd_addr, output a, b, c, d, busy, done, rd_data, sig);
  modport slave (output start, e, f, g, rd_addr, input a, b, c, d, busy, done, rd_data, sig);
endinterface

// File: rtl/nor_vector_gen.sv
// nor_vector_gen: sweeps all 16 input vectors, banks each {e,f,g} response and folds it into an 8-bit MISR
module nor_vector_gen #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 2
) (
  input logic clk,
  input logic rst,
  nor_vector_gen_if.master bus
);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  localparam logic [7:0] SMP  = 8'(SETTLE);
  state_t     state;
  logic [3:0] idx, vec;
  logic [7:0] cnt, sig, sig_nxt;
  logic [2:0] bank [16];
  logic [2:0] resp;
  logic       busy, done;
  assign resp = {bus.e, bus.f, bus.g};
  always_comb sig_nxt = {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {5'b0, resp};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      vec   <= '0;
      cnt   <= '0;
      sig   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        state <= APPLY;
        idx   <= '0;
        vec   <= '0;
        cnt   <= '0;
        sig   <= '0;
        busy  <= 1'b1;
      end
    end else if (state == APPLY) begin
      // exactly one sample per vector, taken once the response has settled
      if (cnt == SMP) begin
        bank[idx] <= resp;
        sig       <= sig_nxt;
      end
      if (cnt == LAST) begin
        cnt <= '0;
        if (idx == 4'd15) begin
          state <= DONE;
          vec   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          idx <= idx + 4'd1;
          vec <= idx + 4'd1;
        end
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      state <= IDLE;
      done  <= 1'b0;
    end
  end
  assign {bus.a, bus.b, bus.c, bus.d} = vec;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.sig     = sig;
  assign bus.rd_data = bank[bus.rd_addr];
endmodule

// File: tb/tb_nor_vector_gen.sv
// tb_nor_vector_gen: drives sweeps into two generators (golden NOR and stuck-g NOR) against an arithmetic model
module tb_nor_vector_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  nor_vector_gen_if i0 ();
  nor_vector_gen_if i1 ();
  assign i0.e = ~(i0.a | i0.b);
  assign i0.f = ~(i0.c | i0.d);
  assign i0.g = ~(i0.a | i0.b | i0.c | i0.d);
  assign i1.e = ~(i1.a | i1.b);
  assign i1.f = ~(i1.c | i1.d);
  assign i1.g = 1'b1;
  nor_vector_gen #(.DWELL(4), .SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(i0.master));
  nor_vector_gen #(.DWELL(2), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.master));
  function automatic int resp(input int v, input bit stuck);
    int e, f, g;
    e = (v / 4) == 0;
    f = (v % 4) == 0;
    g = stuck ? 1 : (v == 0);
    return e * 4 + f * 2 + g;
  endfunction
  function automatic logic [7:0] model_sig(input bit stuck);
    int s = 0;
    for (int v = 0; v < 16; v++) s = ((s * 2) ^ ((s >= 128) ? 29 : 0) ^ resp(v, stuck)) % 256;
    return 8'(s);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sweep0(input int pulse_at);
    @(negedge clk) i0.start = 1'b1;
    @(negedge clk) i0.start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk("busy", 32'(i0.busy), 1);
      chk("vec", 32'({i0.a, i0.b, i0.c, i0.d}), k / 4);
      chk("done_low", 32'(i0.done), 0);
      if (k == pulse_at) i0.start = 1'b1;
      if (k == pulse_at + 1) i0.start = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", 32'(i0.done), 1);
    chk("busy_in_done", 32'(i0.busy), 0);
    chk("vec_in_done", 32'({i0.a, i0.b, i0.c, i0.d}), 0);
    @(negedge clk);
    chk("done_once", 32'(i0.done), 0);
    chk("busy_idle", 32'(i0.busy), 0);
  endtask
  task automatic check_bank0();
    int r = $urandom_range(15, 0);
    for (int i = 0; i < 16; i++) begin
      i0.rd_addr = 4'((i + r) % 16);
      #1 chk("bank0", 32'(i0.rd_data), resp((i + r) % 16, 1'b0));
    end
    chk("sig0", 32'(i0.sig), 32'(model_sig(1'b0)));
  endtask
  initial begin
    int prev, ndone, t, bcnt;
    i0.start = 1'b0;
    i1.start = 1'b0;
    i0.rd_addr = '0;
    i1.rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_sig", 32'(i0.sig), 0);
    chk("rst_busy", 32'(i0.busy), 0);
    chk("rst_done", 32'(i0.done), 0);
    chk("rst_vec", 32'({i0.a, i0.b, i0.c, i0.d}), 0);
    chk("rst_rd", 32'(i0.rd_data), 0);
    rst = 1'b0;
    sweep0(-5);
    check_bank0();
    repeat ($urandom_range(4, 1)) @(negedge clk);
    sweep0(20);
    check_bank0();
    @(negedge clk) i0.start = 1'b1;
    @(negedge clk) i0.start = 1'b0;
    repeat (28) @(negedge clk);
    chk("pre_rst_vec", 32'({i0.a, i0.b, i0.c, i0.d}), 7);
    rst = 1'b1;
    #1;
    chk("arst_vec", 32'({i0.a, i0.b, i0.c, i0.d}), 0);
    chk("arst_busy", 32'(i0.busy), 0);
    chk("arst_sig", 32'(i0.sig), 0);
    for (int i = 0; i < 16; i++) begin
      i0.rd_addr = 4'(i);
      #1 chk("arst_bank", 32'(i0.rd_data), 0);
    end
    @(negedge clk) rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("no_done_abort", 32'(i0.done), 0);
      chk("no_busy_abort", 32'(i0.busy), 0);
    end
    sweep0(-5);
    check_bank0();
    @(negedge clk) i0.start = 1'b1;
    prev = -1;
    ndone = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (i0.done) begin
        ndone++;
        chk("b2b_sig", 32'(i0.sig), 32'(model_sig(1'b0)));
        if (prev >= 0) chk("b2b_gap", 32'(c - prev), 66);
        prev = c;
      end
    end
    i0.start = 1'b0;
    chk("b2b_count", 32'(ndone), 3);
    t = 0;
    while (!i0.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(t < 200), 1);
    @(negedge clk) i1.start = 1'b1;
    @(negedge clk) i1.start = 1'b0;
    bcnt = 0;
    while (i1.busy && bcnt < 100) begin
      bcnt++;
      @(negedge clk);
    end
    chk("stuck_busy_len", 32'(bcnt), 32);
    chk("stuck_done", 32'(i1.done), 1);
    for (int i = 0; i < 16; i++) begin
      i1.rd_addr = 4'(i);
      #1 chk("stuck_bank_lsb", 32'(i1.rd_data[0]), 1);
      chk("stuck_bank", 32'(i1.rd_data), resp(i, 1'b1));
    end
    chk("stuck_sig", 32'(i1.sig), 32'(model_sig(1'b1)));
    chk("stuck_sig_differs", 32'(i1.sig != model_sig(1'b0)), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
